// File: rtl/multi_bank_pingpong_buffer_pkg.sv
// Shared sizing helpers and error-bit indices for the multi-bank ping-pong buffer.
package pingpong_pkg;

   localparam int ERR_WR = 0;
   localparam int ERR_RD = 1;

   function automatic int unsigned ptr_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int unsigned cnt_w(input int unsigned n);
      return $clog2(n + 1);
   endfunction

   function automatic int unsigned addr_w(input int unsigned d);
      return (d > 1) ? $clog2(d) : 1;
   endfunction

endpackage

// File: rtl/multi_bank_pingpong_buffer_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
module sdp_ram #(
   parameter int unsigned WIDTH  = 64,
   parameter int unsigned WORDS  = 32,
   parameter int unsigned ADDR_W = 5,
   parameter string       MODE   = "block"
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);

   if (!(MODE == "block" || MODE == "distributed" || MODE == "ultra")) begin : g_bad_mode
      $error("sdp_ram: unsupported MODE");
   end

   (* ram_style = MODE *) logic [WIDTH-1:0] mem [WORDS];

   logic [WIDTH-1:0] rdata_q, rdata_d;

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Output holds its last value when no read is issued.
   always_comb begin
      rdata_d = rdata_q;
      if (re) begin
         rdata_d = mem[raddr];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/multi_bank_pingpong_buffer.sv
// N-bank ping-pong buffer: writer fills and commits banks in order, reader consumes
// the oldest committed bank and releases it; ownership tracked by pointers and a count.
module multi_bank_pingpong_buffer
   import pingpong_pkg::*;
#(
   parameter int unsigned BIT_LENGTH = 64,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned NUM_BANKS  = 2,
   parameter string       MODE       = "block"
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             wr_en,
   input  logic [addr_w(DEPTH)-1:0]         wr_addr,
   input  logic [BIT_LENGTH-1:0]            wr_data,
   input  logic                             wr_done,
   output logic                             wr_ready,
   output logic [ptr_w(NUM_BANKS)-1:0]      wr_bank,
   input  logic                             rd_en,
   input  logic [addr_w(DEPTH)-1:0]         rd_addr,
   output logic [BIT_LENGTH-1:0]            rd_data,
   output logic                             rd_valid,
   input  logic                             rd_done,
   output logic                             rd_ready,
   output logic [ptr_w(NUM_BANKS)-1:0]      rd_bank,
   output logic [cnt_w(NUM_BANKS)-1:0]      full_cnt,
   output logic [1:0]                       err
);

   localparam int unsigned PW    = ptr_w(NUM_BANKS);
   localparam int unsigned CW    = cnt_w(NUM_BANKS);
   localparam int unsigned AW    = addr_w(DEPTH);
   localparam int unsigned WORDS = NUM_BANKS * DEPTH;

   localparam logic [PW-1:0] LastBank = PW'(NUM_BANKS - 1);
   localparam logic [CW-1:0] AllFull  = CW'(NUM_BANKS);

   logic [PW-1:0] wbank_q, wbank_d;
   logic [PW-1:0] rbank_q, rbank_d;
   logic [CW-1:0] full_cnt_q, full_cnt_d;
   logic          rd_valid_q, rd_valid_d;
   logic [1:0]    err_q, err_d;

   logic wr_acc, wr_commit, rd_acc, rd_rel;

   assign wr_ready  = (full_cnt_q != AllFull);
   assign rd_ready  = (full_cnt_q != '0);
   assign wr_acc    = wr_en & wr_ready;
   assign wr_commit = wr_done & wr_ready;
   assign rd_acc    = rd_en & rd_ready;
   assign rd_rel    = rd_done & rd_ready;

   always_comb begin
      wbank_d    = wbank_q;
      rbank_d    = rbank_q;
      full_cnt_d = full_cnt_q;
      rd_valid_d = rd_acc;
      err_d      = err_q;

      if (wr_commit) begin
         wbank_d = (wbank_q == LastBank) ? '0 : wbank_q + 1'b1;
      end
      if (rd_rel) begin
         rbank_d = (rbank_q == LastBank) ? '0 : rbank_q + 1'b1;
      end

      // Commit and release together leave the count unchanged.
      case ({wr_commit, rd_rel})
         2'b10:   full_cnt_d = full_cnt_q + 1'b1;
         2'b01:   full_cnt_d = full_cnt_q - 1'b1;
         default: full_cnt_d = full_cnt_q;
      endcase

      if ((wr_en | wr_done) & ~wr_ready) begin
         err_d[ERR_WR] = 1'b1;
      end
      if ((rd_en | rd_done) & ~rd_ready) begin
         err_d[ERR_RD] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wbank_q    <= '0;
         rbank_q    <= '0;
         full_cnt_q <= '0;
         rd_valid_q <= 1'b0;
         err_q      <= '0;
      end else begin
         wbank_q    <= wbank_d;
         rbank_q    <= rbank_d;
         full_cnt_q <= full_cnt_d;
         rd_valid_q <= rd_valid_d;
         err_q      <= err_d;
      end
   end

   // DEPTH is a power of two, so {bank, addr} == bank*DEPTH + addr.
   sdp_ram #(
      .WIDTH  (BIT_LENGTH),
      .WORDS  (WORDS),
      .ADDR_W (PW + AW),
      .MODE   (MODE)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_acc & ~rst),
      .waddr ({wbank_q, wr_addr}),
      .wdata (wr_data),
      .re    (rd_acc & ~rst),
      .raddr ({rbank_q, rd_addr}),
      .rdata (rd_data)
   );

   assign wr_bank  = wbank_q;
   assign rd_bank  = rbank_q;
   assign full_cnt = full_cnt_q;
   assign rd_valid = rd_valid_q;
   assign err      = err_q;

endmodule

// File: tb/tb_multi_bank_pingpong_buffer.sv
// Directed bench for multi_bank_pingpong_buffer (3 banks x 16 words) with a per-cycle
// behavioural model and hand-computed spot checks.
module tb_multi_bank_pingpong_buffer;

   localparam int unsigned BL = 64;
   localparam int unsigned D  = 16;
   localparam int unsigned NB = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_en = 1'b0;
   logic [3:0]    wr_addr = '0;
   logic [BL-1:0] wr_data = '0;
   logic          wr_done = 1'b0;
   logic          wr_ready;
   logic [1:0]    wr_bank;
   logic          rd_en = 1'b0;
   logic [3:0]    rd_addr = '0;
   logic [BL-1:0] rd_data;
   logic          rd_valid;
   logic          rd_done = 1'b0;
   logic          rd_ready;
   logic [1:0]    rd_bank;
   logic [1:0]    full_cnt;
   logic [1:0]    err;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   multi_bank_pingpong_buffer #(
      .BIT_LENGTH (BL),
      .DEPTH      (D),
      .NUM_BANKS  (NB),
      .MODE       ("block")
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .wr_done  (wr_done),
      .wr_ready (wr_ready),
      .wr_bank  (wr_bank),
      .rd_en    (rd_en),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .rd_done  (rd_done),
      .rd_ready (rd_ready),
      .rd_bank  (rd_bank),
      .full_cnt (full_cnt),
      .err      (err)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: banks as a 2-D array, committed banks counted as an integer.
   logic [BL-1:0] m_mem [NB][D];
   int            m_wb, m_rb, m_cnt;
   logic [1:0]    m_err;
   logic          m_rv;
   logic [BL-1:0] m_rd;
   bit            m_live = 1'b0;
   bit            m_can_w, m_can_r, m_c, m_r;

   always @(posedge clk) begin
      if (rst) begin
         m_wb = 0; m_rb = 0; m_cnt = 0; m_err = 2'b00; m_rv = 1'b0; m_rd = '0;
         m_live = 1'b1;
      end else if (m_live) begin
         m_can_w = (m_cnt < int'(NB));
         m_can_r = (m_cnt > 0);
         m_c = 1'b0;
         m_r = 1'b0;
         m_rv = 1'b0;
         if (rd_en) begin
            if (m_can_r) begin
               m_rd = m_mem[m_rb][rd_addr];
               m_rv = 1'b1;
            end else m_err[1] = 1'b1;
         end
         if (rd_done) begin
            if (m_can_r) m_r = 1'b1;
            else m_err[1] = 1'b1;
         end
         if (wr_en) begin
            if (m_can_w) m_mem[m_wb][wr_addr] = wr_data;
            else m_err[0] = 1'b1;
         end
         if (wr_done) begin
            if (m_can_w) m_c = 1'b1;
            else m_err[0] = 1'b1;
         end
         if (m_c) m_wb = (m_wb + 1) % int'(NB);
         if (m_r) m_rb = (m_rb + 1) % int'(NB);
         m_cnt = m_cnt + int'(m_c) - int'(m_r);
      end
   end

   always @(negedge clk) begin
      if (m_live) begin
         chk("m_wr_ready", 64'(wr_ready), 64'(m_cnt != int'(NB)));
         chk("m_rd_ready", 64'(rd_ready), 64'(m_cnt != 0));
         chk("m_wr_bank",  64'(wr_bank),  64'(m_wb));
         chk("m_rd_bank",  64'(rd_bank),  64'(m_rb));
         chk("m_full_cnt", 64'(full_cnt), 64'(m_cnt));
         chk("m_err",      64'(err),      64'(m_err));
         chk("m_rd_valid", 64'(rd_valid), 64'(m_rv));
         chk("m_rd_data",  rd_data,       m_rd);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
      wr_en = 1'b0; wr_done = 1'b0; rd_en = 1'b0; rd_done = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
   endtask

   // Last word is written in the commit cycle.
   task automatic fill_bank(input logic [63:0] base);
      for (int a = 0; a < int'(D); a++) begin
         wr_en = 1'b1; wr_addr = 4'(a); wr_data = base + 64'(a);
         wr_done = (a == int'(D) - 1);
         cyc();
      end
   endtask

   task automatic drain_bank(input logic [63:0] base, input bit rel);
      for (int a = 0; a < int'(D); a++) begin
         rd_en = 1'b1; rd_addr = 4'(a);
         rd_done = rel && (a == int'(D) - 1);
         cyc();
         chk("drain_valid", 64'(rd_valid), 64'd1);
         chk("drain_data", rd_data, base + 64'(a));
      end
   endtask

   initial begin
      cyc();
      do_reset();
      chk("rst_full_cnt", 64'(full_cnt), 64'd0);
      chk("rst_wr_ready", 64'(wr_ready), 64'd1);
      chk("rst_rd_ready", 64'(rd_ready), 64'd0);
      chk("rst_err",      64'(err),      64'd0);
      chk("rst_rd_data",  rd_data,       64'd0);

      // Fill bank 0 with addr+0x100, then commit separately.
      for (int a = 0; a < int'(D); a++) begin
         wr_en = 1'b1; wr_addr = 4'(a); wr_data = 64'h100 + 64'(a);
         cyc();
      end
      wr_done = 1'b1;
      cyc();
      chk("t1_full_cnt", 64'(full_cnt), 64'd1);
      chk("t1_wr_bank",  64'(wr_bank),  64'd1);
      chk("t1_rd_ready", 64'(rd_ready), 64'd1);
      rd_en = 1'b1; rd_addr = 4'd5;
      cyc();
      chk("t1_rd_valid", 64'(rd_valid), 64'd1);
      chk("t1_rd_data",  rd_data,       64'h105);
      cyc();
      chk("t1_valid_drop", 64'(rd_valid), 64'd0);
      chk("t1_data_hold",  rd_data,       64'h105);

      // Simultaneous commit and release at full_cnt=1.
      wr_done = 1'b1; rd_done = 1'b1;
      cyc();
      chk("t4_full_cnt", 64'(full_cnt), 64'd1);
      chk("t4_wr_bank",  64'(wr_bank),  64'd2);
      chk("t4_rd_bank",  64'(rd_bank),  64'd1);

      // Reads and releases with nothing committed.
      do_reset();
      rd_en = 1'b1; rd_addr = 4'd3;
      cyc();
      chk("t3_rd_valid", 64'(rd_valid), 64'd0);
      chk("t3_err",      64'(err),      64'd2);
      rd_done = 1'b1;
      cyc();
      chk("t3_rd_bank", 64'(rd_bank), 64'd0);
      chk("t3_err_hold", 64'(err), 64'd2);

      // Fill all three banks, then violate on the write side.
      do_reset();
      for (int k = 0; k < int'(NB); k++) fill_bank(64'(k * 16));
      chk("t2_full_cnt", 64'(full_cnt), 64'd3);
      chk("t2_wr_ready", 64'(wr_ready), 64'd0);
      wr_en = 1'b1; wr_addr = 4'd0; wr_data = 64'hDEAD;
      cyc();
      chk("t2_err", 64'(err), 64'd1);
      wr_done = 1'b1;
      cyc();
      chk("t2_full_hold", 64'(full_cnt), 64'd3);
      chk("t2_wbank_hold", 64'(wr_bank), 64'd0);
      drain_bank(64'h0, 1'b0);
      rd_done = 1'b1;
      cyc();
      chk("t2_after_rel", 64'(full_cnt), 64'd2);

      // Seven commit/release pairs wrap both pointers around three banks.
      do_reset();
      for (int i = 0; i < 7; i++) begin
         fill_bank(64'((i % int'(NB)) * 16));
         drain_bank(64'((i % int'(NB)) * 16), 1'b1);
      end
      chk("t5_wr_bank",  64'(wr_bank),  64'd1);
      chk("t5_rd_bank",  64'(rd_bank),  64'd1);
      chk("t5_full_cnt", 64'(full_cnt), 64'd0);

      // Reset with two committed banks and a sticky error; inputs in the reset cycle ignored.
      do_reset();
      rd_en = 1'b1;
      cyc();
      fill_bank(64'h0);
      fill_bank(64'h10);
      chk("t6_pre_full", 64'(full_cnt), 64'd2);
      chk("t6_pre_err",  64'(err),      64'd2);
      rst = 1'b1; wr_en = 1'b1; wr_done = 1'b1; wr_addr = 4'd0; wr_data = 64'hBAD;
      cyc();
      rst = 1'b0;
      chk("t6_full_cnt", 64'(full_cnt), 64'd0);
      chk("t6_wr_ready", 64'(wr_ready), 64'd1);
      chk("t6_rd_ready", 64'(rd_ready), 64'd0);
      chk("t6_wr_bank",  64'(wr_bank),  64'd0);
      chk("t6_rd_bank",  64'(rd_bank),  64'd0);
      chk("t6_err",      64'(err),      64'd0);
      cyc();
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
